div_hilo_ctrl: RTL
==================

# div_hilo_ctrl

Sequencing and result stage wrapped around the iterative divider. It accepts DIV/DIVU requests from decode, converts signed operands to magnitudes, and starts the divider. It waits for completion, applies the MIPS sign rules to quotient and remainder, and commits them to the architectural HI/LO registers, which it also owns for MTHI/MTLO writes and MFHI/MFLO reads.

## Interface
- WIDTH, 32, operand/result width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- op_valid  in  1  divide request, sampled only in IDLE
- op_signed  in  1  1 = DIV (signed), 0 = DIVU
- op_a  in  WIDTH  dividend
- op_b  in  WIDTH  divisor
- busy  out  1  high while a division is in flight; decode stalls on it
- div_start  out  1  one-cycle start pulse to divider
- div_a  out  WIDTH  dividend magnitude to divider (registered)
- div_b  out  WIDTH  divisor magnitude to divider (registered)
- div_done  in  1  divider result valid, sampled only in WAIT
- div_lo  in  WIDTH  unsigned quotient from divider
- div_hi  in  WIDTH  unsigned remainder from divider
- mthi  in  1  write wdata to HI
- mtlo  in  1  write wdata to LO
- wdata  in  WIDTH  MTHI/MTLO data
- hi  out  WIDTH  architectural HI
- lo  out  WIDTH  architectural LO
- div_by_zero  out  1  one-cycle flag, divide with op_b == 0

## Operation
- States: IDLE, ISSUE, WAIT, FIXUP. busy = (state != IDLE), combinational.
- IDLE, op_valid=1, op_b != 0:
  - Capture sign_q = op_signed & (a[MSB]^b[MSB]) and sign_r = op_signed & a[MSB].
  - Load div_a = (op_signed & a[MSB]) ? -op_a : op_a. Load div_b likewise.
  - Go to ISSUE.
- IDLE, op_valid=1, op_b == 0:
  - No divider start. HI <= op_a, LO <= all-ones, div_by_zero=1 for one cycle.
  - Stay in IDLE.
- ISSUE: div_start=1 for exactly this cycle; go to WAIT.
- WAIT: hold div_a/div_b stable. On div_done=1, register div_lo/div_hi and go to FIXUP.
- FIXUP:
  - LO <= sign_q ? -q : q.
  - HI <= sign_r ? -r : r.
  - Return to IDLE.
- Arithmetic: two's-complement negation modulo 2^WIDTH. The magnitude of 0x80000000 is 0x80000000 as unsigned, so no overflow handling is needed.
- MTHI/MTLO: honoured only in IDLE; asserting both writes wdata to both. They are ignored while busy, because decode is stalled.
- op_valid and mthi/mtlo in the same IDLE cycle:
  - The move is written; the divide is accepted.
  - The FIXUP commit later overwrites HI and LO.
  - For op_b == 0, the div-by-zero write takes priority over the move.
- op_valid while busy: ignored. Upstream holds the request until busy falls.
- div_done outside WAIT: ignored. This covers a stale done after reset or in ISSUE.
- No timeout: WAIT persists until div_done.

## Timing
- Reset values: state=IDLE, hi=0, lo=0, div_a=0, div_b=0, div_start=0, div_by_zero=0, busy=0, sign flags 0.
- Reset mid-operation: return to IDLE immediately, clear HI/LO, abort the in-flight division; its eventual div_done is discarded.
- Cycle map (edge n = request accepted):
  - Request sampled at edge n.
  - ISSUE during cycle n+1; div_start high and busy high.
  - WAIT from cycle n+2.
  - div_done sampled at edge m; FIXUP during cycle m+1.
  - hi/lo updated at edge m+2; busy low from cycle m+2.
- Controller overhead is 3 cycles beyond divider latency. The next request is accepted at edge m+2.
- Div-by-zero: hi/lo and div_by_zero update at edge n+1; busy never rises.
- MTHI/MTLO: hi/lo update at the next edge.
- hi/lo are registered, with no bypass. MFHI/MFLO read them directly.

## Test plan
- Unsigned 100/7 (op_signed=0) -> div_a=100, div_b=7, one div_start pulse; after done, LO=14, HI=2, busy low 3 cycles after done.
- Signed -7/2 (0xFFFFFFF9, 2) -> div_a=7, div_b=2; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Signed 7/-2 -> LO=0xFFFFFFFD, HI=1.
- Signed 0x80000000/0xFFFFFFFF -> div_a=0x80000000, div_b=1; LO=0x80000000, HI=0.
- op_a=5, op_b=0 -> no div_start, busy stays 0, div_by_zero one-cycle pulse, HI=5, LO=0xFFFFFFFF.
- Assert reset low during WAIT -> busy=0, hi=lo=0 immediately. A later div_done pulse leaves state IDLE and hi/lo unchanged.
- mthi with wdata=0x1234 in IDLE -> HI=0x1234 next edge. mtlo asserted while busy -> LO unchanged.

Source files
------------

// File: rtl/div_hilo_ctrl.sv
// Divide sequencing and result stage: takes DIV/DIVU requests, feeds operand
// magnitudes to the iterative divider, applies MIPS sign rules and owns HI/LO.
module div_hilo_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_lo,
  input  logic [WIDTH-1:0] div_hi,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIXUP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_b_q, div_b_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             sgn_quo_q, sgn_quo_d;
  logic             sgn_rem_q, sgn_rem_d;
  logic             dbz_q, dbz_d;
  logic             neg_a, neg_b;

  // Two's-complement negation wraps, so the most negative value maps to itself
  // and reads correctly as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                input logic             neg);
    return neg ? ((~x) + WIDTH'(1)) : x;
  endfunction

  assign neg_a = op_signed & op_a[WIDTH-1];
  assign neg_b = op_signed & op_b[WIDTH-1];

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    div_a_d   = div_a_q;
    div_b_d   = div_b_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    dbz_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        // A same-cycle move lands now; a divide result overwrites it later.
        if (op_valid) begin
          if (op_b == '0) begin
            hi_d  = op_a;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            sgn_quo_d = neg_a ^ neg_b;
            sgn_rem_d = neg_a;
            div_a_d   = cond_neg(op_a, neg_a);
            div_b_d   = cond_neg(op_b, neg_b);
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (div_done) begin
          quo_d   = div_lo;
          rem_d   = div_hi;
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        lo_d    = cond_neg(quo_q, sgn_quo_q);
        hi_d    = cond_neg(rem_q, sgn_rem_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      div_a_q   <= '0;
      div_b_q   <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      div_a_q   <= div_a_d;
      div_b_q   <= div_b_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign div_start   = (state_q == ISSUE);
  assign div_a       = div_a_q;
  assign div_b       = div_b_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
